// File: rtl/sevenseg_display_scheduler.sv
// Scans N_DIGITS common-anode displays through one shared hex decoder, with a blanking
// gap before each digit and a once-per-frame snapshot of the display word.
module sevenseg_display_scheduler #(
  parameter int N_DIGITS     = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [2:0]            digit_sel,
  output logic                  frame_tick
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int SW   = $clog2(N_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [2:0]    LAST_SEL   = 3'(N_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  load_pending;
  logic [4*N_DIGITS-1:0] data_snap;
  logic [N_DIGITS-1:0]   en_snap;

  logic                  slot_end;
  logic                  wrap;
  logic [2:0]            next_sel;
  logic [4*N_DIGITS-1:0] next_data;
  logic                  cur_lit;
  logic [N_DIGITS-1:0]   cur_drive;

  // Outputs are loaded from the values the registers take on the same edge, so
  // anodes/bcd_out line up exactly with the state they describe.
  always_comb begin
    slot_end  = (state == DRIVE) && (cnt == DRIVE_LAST);
    wrap      = slot_end && (digit_sel == LAST_SEL);
    next_sel  = wrap ? 3'd0 : digit_sel + 3'd1;
    next_data = wrap ? data_in : data_snap;
    cur_lit   = en_snap[digit_sel[SW-1:0]];
    cur_drive = ~({{(N_DIGITS-1){1'b0}}, cur_lit} << digit_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BLANK;
      cnt          <= '0;
      digit_sel    <= '0;
      anodes       <= '1;
      bcd_out      <= '0;
      frame_tick   <= 1'b0;
      data_snap    <= '0;
      en_snap      <= '0;
      load_pending <= 1'b1;
    end else begin
      frame_tick <= 1'b0;
      if (load_pending) begin
        // First edge after reset only takes the snapshot; the scan starts next cycle.
        load_pending <= 1'b0;
        data_snap    <= data_in;
        en_snap      <= digit_en;
        frame_tick   <= 1'b1;
        bcd_out      <= data_in[3:0];
      end else begin
        case (state)
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state  <= DRIVE;
              cnt    <= '0;
              anodes <= cur_drive;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DRIVE: begin
            if (slot_end) begin
              state     <= BLANK;
              cnt       <= '0;
              digit_sel <= next_sel;
              anodes    <= '1;
              bcd_out   <= next_data[4*next_sel +: 4];
              if (wrap) begin
                data_snap  <= data_in;
                en_snap    <= digit_en;
                frame_tick <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= BLANK;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_display_scheduler.sv
// Bench for sevenseg_display_scheduler: outputs are predicted from the cycle index since
// reset release and the per-frame input snapshot, using plain slot/frame arithmetic.
module tb_sevenseg_display_scheduler;

  localparam int N     = 8;
  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  digit_en = '0;
  logic [3:0]  bcd_out;
  logic [7:0]  anodes;
  logic [2:0]  digit_sel;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail = 0;
  int t = 0;
  logic [31:0] ref_d = '0;
  logic [7:0]  ref_e = '0;

  sevenseg_display_scheduler #(
    .N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .digit_en(digit_en),
    .bcd_out(bcd_out), .anodes(anodes), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: cycle t (after edge t) shows state u = t-1 within a 48-cycle frame.
  function automatic logic [7:0] m_an();
    int p, k, ph;
    if (t == 0) return 8'hFF;
    p = (t - 1) % FRAME; k = p / SLOT; ph = p % SLOT;
    if (ph >= BC && ref_e[k]) return ~(8'h01 << k);
    return 8'hFF;
  endfunction

  function automatic logic [3:0] m_bcd();
    int k;
    if (t == 0) return 4'h0;
    k = ((t - 1) % FRAME) / SLOT;
    return ref_d[4*k +: 4];
  endfunction

  function automatic logic [2:0] m_sel();
    if (t == 0) return 3'd0;
    return 3'(((t - 1) % FRAME) / SLOT);
  endfunction

  function automatic logic m_tick();
    return (t >= 1) && (((t - 1) % FRAME) == 0);
  endfunction

  // One clock: remember what the DUT samples, advance, update the snapshot model.
  task automatic step();
    logic [31:0] cd;
    logic [7:0]  ce;
    cd = data_in;
    ce = digit_en;
    @(posedge clk);
    t++;
    if (((t - 1) % FRAME) == 0) begin
      ref_d = cd;
      ref_e = ce;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0; ref_d = '0; ref_e = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_in = 32'hDEADBEEF;
    digit_en = 8'hFF;
    @(posedge clk); #1;
    if ({anodes, bcd_out, digit_sel, frame_tick} !== {8'hFF, 4'h0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values an=%h bcd=%h sel=%0d tick=%b required an=ff bcd=0 sel=0 tick=0",
               anodes, bcd_out, digit_sel, frame_tick);
    end
    n_checks++;
    @(posedge clk); #1;
    reset = 1'b0;
    t = 0; ref_d = '0; ref_e = '0;
    step();
    if ({frame_tick, bcd_out, anodes} !== {1'b1, 4'hF, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_first_load tick=%b bcd=%h an=%h required tick=1 bcd=f an=ff",
               frame_tick, bcd_out, anodes);
    end
    n_checks++;
  endtask

  task automatic test_scan_order();
    do_reset();
    data_in = 32'h76543210;
    digit_en = 8'hFF;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if ({anodes, bcd_out, digit_sel, frame_tick} !== {m_an(), m_bcd(), m_sel(), m_tick()}) begin
        n_fail++;
        $display("FAIL scan t=%0d got an=%h bcd=%h sel=%0d tick=%b required an=%h bcd=%h sel=%0d tick=%b",
                 t, anodes, bcd_out, digit_sel, frame_tick, m_an(), m_bcd(), m_sel(), m_tick());
      end
      n_checks++;
      if (t == 3 || t == 45) begin
        if ({anodes, bcd_out} !== ((t == 3) ? {8'hFE, 4'h0} : {8'h7F, 4'h7})) begin
          n_fail++;
          $display("FAIL scan_drive t=%0d an=%h bcd=%h", t, anodes, bcd_out);
        end
        n_checks++;
      end
    end
  endtask

  task automatic test_tear_free();
    while (t < 100) begin
      step();
      if (t == 69) data_in = 32'hFFFFFFFF;
      if ({anodes, bcd_out, digit_sel, frame_tick} !== {m_an(), m_bcd(), m_sel(), m_tick()}) begin
        n_fail++;
        $display("FAIL tear t=%0d got an=%h bcd=%h sel=%0d tick=%b required an=%h bcd=%h sel=%0d tick=%b",
                 t, anodes, bcd_out, digit_sel, frame_tick, m_an(), m_bcd(), m_sel(), m_tick());
      end
      n_checks++;
      if (t == 84 && bcd_out !== 4'h5) begin
        n_fail++;
        $display("FAIL tear_old_value bcd=%h required 5", bcd_out);
      end
      if (t == 84) n_checks++;
      if (t == 97 && {frame_tick, bcd_out} !== {1'b1, 4'hF}) begin
        n_fail++;
        $display("FAIL tear_new_frame tick=%b bcd=%h required tick=1 bcd=f", frame_tick, bcd_out);
      end
      if (t == 97) n_checks++;
    end
  endtask

  task automatic test_masking();
    int lit_cycles = 0;
    int ticks = 0;
    do_reset();
    data_in = $urandom;
    digit_en = 8'h0F;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (anodes != 8'hFF) lit_cycles++;
      if (frame_tick) ticks++;
      if ({anodes, bcd_out, digit_sel, frame_tick} !== {m_an(), m_bcd(), m_sel(), m_tick()}) begin
        n_fail++;
        $display("FAIL mask t=%0d got an=%h bcd=%h sel=%0d tick=%b required an=%h bcd=%h sel=%0d tick=%b",
                 t, anodes, bcd_out, digit_sel, frame_tick, m_an(), m_bcd(), m_sel(), m_tick());
      end
      n_checks++;
    end
    if (lit_cycles != 2 * 4 * DC || ticks != 2) begin
      n_fail++;
      $display("FAIL mask_totals lit=%0d ticks=%0d required lit=%0d ticks=2", lit_cycles, ticks, 2 * 4 * DC);
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_in = 32'h76543210;
    digit_en = 8'hFF;
    while (t < 35) step();
    if (anodes !== 8'hDF) begin
      n_fail++;
      $display("FAIL mid_pre_reset an=%h required df", anodes);
    end
    n_checks++;
    reset = 1'b1;
    #1;
    if ({anodes, bcd_out, digit_sel} !== {8'hFF, 4'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL mid_async an=%h bcd=%h sel=%0d required an=ff bcd=0 sel=0", anodes, bcd_out, digit_sel);
    end
    n_checks++;
    @(posedge clk); #1;
    reset = 1'b0;
    t = 0; ref_d = '0; ref_e = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({anodes, digit_sel} !== {((t == 3) ? 8'hFE : 8'hFF), 3'd0}) begin
        n_fail++;
        $display("FAIL mid_restart t=%0d an=%h sel=%0d required an=%h sel=0",
                 t, anodes, digit_sel, (t == 3) ? 8'hFE : 8'hFF);
      end
      n_checks++;
    end
  endtask

  task automatic test_frame_tick();
    int ticks = 0;
    int first = -1;
    int last = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_tick) begin
        ticks++;
        if (first < 0) first = t;
        last = t;
      end
      if (frame_tick !== m_tick()) begin
        n_fail++;
        $display("FAIL tick t=%0d got %b required %b", t, frame_tick, m_tick());
      end
      n_checks++;
    end
    if (ticks != 3 || (last - first) != 2 * FRAME) begin
      n_fail++;
      $display("FAIL tick_period count=%0d span=%0d required count=3 span=%0d", ticks, last - first, 2 * FRAME);
    end
    n_checks++;
  endtask

  task automatic test_random_invariant();
    int prev_k = -1;
    int k;
    bit blank_seen = 1'b1;
    do_reset();
    for (int i = 0; i < 4 * FRAME; i++) begin
      data_in = $urandom;
      digit_en = 8'($urandom_range(0, 255));
      step();
      if ({anodes, bcd_out, digit_sel, frame_tick} !== {m_an(), m_bcd(), m_sel(), m_tick()}) begin
        n_fail++;
        $display("FAIL random t=%0d got an=%h bcd=%h sel=%0d tick=%b required an=%h bcd=%h sel=%0d tick=%b",
                 t, anodes, bcd_out, digit_sel, frame_tick, m_an(), m_bcd(), m_sel(), m_tick());
      end
      n_checks++;
      if ($countones(~anodes) > 1) begin
        n_fail++;
        $display("FAIL one_hot t=%0d an=%h required at most one low bit", t, anodes);
      end
      n_checks++;
      if (anodes != 8'hFF) begin
        k = 0;
        for (int b = 0; b < N; b++) if (!anodes[b]) k = b;
        if (prev_k >= 0 && k != prev_k) begin
          if (!blank_seen) begin
            n_fail++;
            $display("FAIL ghost_gap t=%0d digit %0d followed %0d with no blank cycle", t, k, prev_k);
          end
          n_checks++;
        end
        prev_k = k;
        blank_seen = 1'b0;
      end else begin
        blank_seen = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_tear_free();
    test_masking();
    test_reset_mid();
    test_frame_tick();
    test_random_invariant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
